vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator and pixel-fetch sequencer for the display path. It produces pixel-RAM row/column addresses and an active-low read strobe, accepts pixel data from a source with a configurable read latency, and emits colour, hsync and vsync mutually aligned at the connector. It also provides frame/line markers for the game logic. All timing, polarity, latency and colour widths are set by parameters, so one block serves 640x480 and other modes.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_delay_line.sv | 23 ++
 rtl/vga_timing_gen.sv | 117 +++++++++++
 tb/tb_vga_timing_gen.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants (640x480@60 defaults), the delayed-term record and a width helper.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL  = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_V_TOTAL  = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_H_START  = DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_START  = DEF_V_SYNC + DEF_V_BP;

    // Raw (polarity-free) raster terms; all-zero is the idle/flushed value.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic line_start;
        logic frame_start;
    } vga_term_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Display-path bundle: pixel-RAM fetch (address, strobe, data) plus connector-side colour/sync/markers.
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int CW    = 4,
    parameter int ROW_W = clog2(DEF_V_ACTIVE),
    parameter int COL_W = clog2(DEF_H_ACTIVE)
);
    logic [3*CW-1:0]  d_in;
    logic [ROW_W-1:0] row_addr;
    logic [COL_W-1:0] col_addr;
    logic             rdn;
    logic [CW-1:0]    r;
    logic [CW-1:0]    g;
    logic [CW-1:0]    b;
    logic             hs;
    logic             vs;
    logic             de;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  d_in,
        output row_addr, col_addr, rdn, r, g, b, hs, vs, de, line_start, frame_start
    );

    modport slave (
        output d_in,
        input  row_addr, col_addr, rdn, r, g, b, hs, vs, de, line_start, frame_start
    );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register for raster terms; latency DEPTH cycles, synchronous clear flushes every stage.
module vga_delay_line #(
    parameter int DEPTH = 2,
    parameter int W     = 5
) (
    input  logic         vga_clk,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge vga_clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters + pixel-fetch sequencer; addresses 1 cycle after the count, colour/sync/markers FETCH_LAT+2.
// Free-running at the pixel rate: no backpressure, the RAM must return data exactly FETCH_LAT cycles later.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int FETCH_LAT = 1,
    parameter int CW        = 4
) (
    input logic              vga_clk,
    input logic              clr,
    vga_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;
    localparam int HW      = clog2(H_TOTAL);
    localparam int VW      = clog2(V_TOTAL);
    localparam int COL_W   = clog2(H_ACTIVE);
    localparam int ROW_W   = clog2(V_ACTIVE);

    logic [HW-1:0]   h_count;
    logic [VW-1:0]   v_count;
    logic            h_last;
    logic            v_last;
    logic            h_act;
    logic            v_act;
    logic [3*CW-1:0] pix;
    vga_term_t       term_now;
    vga_term_t       term_dly;

    assign h_last = (h_count == HW'(H_TOTAL - 1));
    assign v_last = (v_count == VW'(V_TOTAL - 1));
    assign h_act  = (h_count >= HW'(H_START)) && (h_count < HW'(H_START + H_ACTIVE));
    assign v_act  = (v_count >= VW'(V_START)) && (v_count < VW'(V_START + V_ACTIVE));
    assign pix    = vif.d_in;

    always_ff @(posedge vga_clk) begin
        if (clr) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_last) begin
            h_count <= '0;
            v_count <= v_last ? '0 : v_count + VW'(1);
        end else begin
            h_count <= h_count + HW'(1);
        end
    end

    // Fetch request leaves one cycle after the count; the RAM sees a registered address.
    always_ff @(posedge vga_clk) begin
        if (clr) begin
            vif.row_addr <= '0;
            vif.col_addr <= '0;
            vif.rdn      <= 1'b1;
        end else begin
            vif.row_addr <= ROW_W'(v_count - VW'(V_START));
            vif.col_addr <= COL_W'(h_count - HW'(H_START));
            vif.rdn      <= ~(h_act && v_act);
        end
    end

    always_comb begin
        term_now             = '0;
        term_now.active      = h_act && v_act;
        term_now.hsync       = (h_count < HW'(H_SYNC));
        term_now.vsync       = (v_count < VW'(V_SYNC));
        term_now.line_start  = h_act && v_act && (h_count == HW'(H_START));
        term_now.frame_start = h_act && v_act && (h_count == HW'(H_START))
                               && (v_count == VW'(V_START));
    end

    // One stage for the address register plus FETCH_LAT for the RAM, so terms meet d_in.
    vga_delay_line #(
        .DEPTH (FETCH_LAT + 1),
        .W     ($bits(vga_term_t))
    ) u_dly (
        .vga_clk (vga_clk),
        .clr     (clr),
        .din     (term_now),
        .dout    (term_dly)
    );

    always_ff @(posedge vga_clk) begin
        if (clr) begin
            vif.r           <= '0;
            vif.g           <= '0;
            vif.b           <= '0;
            vif.de          <= 1'b0;
            vif.hs          <= ~HS_POL;
            vif.vs          <= ~VS_POL;
            vif.line_start  <= 1'b0;
            vif.frame_start <= 1'b0;
        end else begin
            vif.de          <= term_dly.active;
            vif.hs          <= term_dly.hsync ? HS_POL : ~HS_POL;
            vif.vs          <= term_dly.vsync ? VS_POL : ~VS_POL;
            vif.line_start  <= term_dly.line_start;
            vif.frame_start <= term_dly.frame_start;
            if (term_dly.active) begin
                {vif.b, vif.g, vif.r} <= pix;
            end else begin
                {vif.b, vif.g, vif.r} <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: several vga_timing_gen instances (default/FETCH_LAT 1..4/inverted polarity/tiny mode) against a raster model.
module tb_vga_timing_gen;

    typedef struct {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
        bit hpol; bit vpol; int fl; bit ram;
    } mode_t;

    typedef struct {
        int x;
        int y;
        logic [11:0] exp_pix;
    } pix_vec_t;

    logic clk;
    logic clr_a;
    logic clr_rest;
    bit   run;
    int   n_err;
    int   n_checks;
    int   leak_a;
    int   leak_b;
    int   e_a, e_b, e_c;
    logic [11:0] ds_a, ds_c;
    logic [11:0] ram_b [3];
    logic [11:0] pix_b [int];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    function automatic mode_t mk(input int ha, hfp, hs, hbp, va, vfp, vs, vbp,
                                 input bit hp, vp, input int fl, input bit ram);
        mode_t m;
        m.ha = ha; m.hfp = hfp; m.hs = hs; m.hbp = hbp;
        m.va = va; m.vfp = vfp; m.vs = vs; m.vbp = vbp;
        m.hpol = hp; m.vpol = vp; m.fl = fl; m.ram = ram;
        return m;
    endfunction

    function automatic logic [11:0] ramf(input int row, input int col);
        return {4'(row), 8'(col)};
    endfunction

    // Reference: after e non-reset edges the address regs describe raster position e-1,
    // the connector outputs describe position e-(FETCH_LAT+2).
    task automatic mcheck(input string nm, input mode_t m, input int e, input logic [11:0] dsamp,
                          input logic rdn, input int row, input int col, input logic [11:0] rgb,
                          input logic hs, vs, de, ls, fs);
        int ht, vt, hst, vst, p, h, v, xrow, xcol;
        logic xr, xhs, xvs, xde, xls, xfs;
        logic [11:0] xrgb;
        logic [63:0] ev, av;
        ht = m.hs + m.hbp + m.ha + m.hfp;
        vt = m.vs + m.vbp + m.va + m.vfp;
        hst = m.hs + m.hbp;
        vst = m.vs + m.vbp;
        xr = 1'b1; xrow = 0; xcol = 0; xrgb = '0;
        xhs = ~m.hpol; xvs = ~m.vpol; xde = 1'b0; xls = 1'b0; xfs = 1'b0;
        if (e >= 1) begin
            p = e - 1; h = p % ht; v = (p / ht) % vt;
            if (h >= hst && h < hst + m.ha && v >= vst && v < vst + m.va) begin
                xr = 1'b0; xrow = v - vst; xcol = h - hst;
            end
        end
        if (e >= m.fl + 2) begin
            p = e - m.fl - 2; h = p % ht; v = (p / ht) % vt;
            xhs = (h < m.hs) ? m.hpol : ~m.hpol;
            xvs = (v < m.vs) ? m.vpol : ~m.vpol;
            if (h >= hst && h < hst + m.ha && v >= vst && v < vst + m.va) begin
                xde = 1'b1;
                xls = (h == hst);
                xfs = (h == hst) && (v == vst);
                xrgb = m.ram ? {4'(v - vst), 8'(h - hst)} : dsamp;
            end
        end
        ev = {14'b0, xr, 16'(xrow), 16'(xcol), xrgb, xhs, xvs, xde, xls, xfs};
        av = {14'b0, rdn, xr ? 16'h0 : 16'(row), xr ? 16'h0 : 16'(col), rgb, hs, vs, de, ls, fs};
        check($sformatf("model_%s@%0d", nm, e), av, ev);
    endtask

    // ---------------- instance A: defaults, FETCH_LAT=1, random pixel data
    vga_timing_gen_if #(.CW(4), .ROW_W(9), .COL_W(10)) if_a ();
    vga_timing_gen #(.FETCH_LAT(1)) u_a (.vga_clk(clk), .clr(clr_a), .vif(if_a));

    // ---------------- instance B: defaults, FETCH_LAT=3, RAM returning {row[3:0], col[7:0]}
    vga_timing_gen_if #(.CW(4), .ROW_W(9), .COL_W(10)) if_b ();
    vga_timing_gen #(.FETCH_LAT(3)) u_b (.vga_clk(clk), .clr(clr_rest), .vif(if_b));

    // ---------------- instance C: defaults, active-high syncs, FETCH_LAT=2
    vga_timing_gen_if #(.CW(4), .ROW_W(9), .COL_W(10)) if_c ();
    vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b1), .FETCH_LAT(2)) u_c (.vga_clk(clk), .clr(clr_rest), .vif(if_c));

    initial begin
        if_a.d_in = '0;
        if_c.d_in = '0;
        forever begin
            @(negedge clk);
            if_a.d_in = 12'($urandom);
            if_c.d_in = 12'($urandom);
        end
    end

    always @(posedge clk) begin
        e_a <= clr_a ? 0 : e_a + 1;
        e_b <= clr_rest ? 0 : e_b + 1;
        e_c <= clr_rest ? 0 : e_c + 1;
        ds_a <= if_a.d_in;
        ds_c <= if_c.d_in;
        ram_b[0] <= if_b.rdn ? 12'($urandom) : ramf(int'(if_b.row_addr), int'(if_b.col_addr));
        ram_b[1] <= ram_b[0];
        ram_b[2] <= ram_b[1];
    end
    assign if_b.d_in = ram_b[2];

    always @(negedge clk) begin
        if (run) begin
            int p, h, v;
            mcheck("a", mk(640,16,96,48,480,10,2,33,0,0,1,0), e_a, ds_a, if_a.rdn, int'(if_a.row_addr),
                   int'(if_a.col_addr), {if_a.b, if_a.g, if_a.r}, if_a.hs, if_a.vs, if_a.de,
                   if_a.line_start, if_a.frame_start);
            mcheck("b", mk(640,16,96,48,480,10,2,33,0,0,3,1), e_b, 12'h0, if_b.rdn, int'(if_b.row_addr),
                   int'(if_b.col_addr), {if_b.b, if_b.g, if_b.r}, if_b.hs, if_b.vs, if_b.de,
                   if_b.line_start, if_b.frame_start);
            mcheck("c", mk(640,16,96,48,480,10,2,33,1,1,2,0), e_c, ds_c, if_c.rdn, int'(if_c.row_addr),
                   int'(if_c.col_addr), {if_c.b, if_c.g, if_c.r}, if_c.hs, if_c.vs, if_c.de,
                   if_c.line_start, if_c.frame_start);
            if (!if_a.de && {if_a.b, if_a.g, if_a.r} != 12'h0) leak_a++;
            if (!if_b.de && {if_b.b, if_b.g, if_b.r} != 12'h0) leak_b++;
            if (e_b >= 5) begin
                p = e_b - 5; h = p % 800; v = (p / 800) % 525;
                if (h >= 144 && h < 784 && v >= 35 && v < 43)
                    pix_b[(v - 35) * 1024 + (h - 144)] = {if_b.b, if_b.g, if_b.r};
            end
        end
    end

    // ---------------- tiny mode H 4/1/2/1, V 3/1/1/1 swept over FETCH_LAT 1..4
    for (genvar gi = 0; gi < 4; gi++) begin : g_s
        vga_timing_gen_if #(.CW(4), .ROW_W(2), .COL_W(2)) ifs ();
        vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                         .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                         .FETCH_LAT(gi + 1)) u_s (.vga_clk(clk), .clr(clr_rest), .vif(ifs));
        logic [11:0] ram [4];
        int e_s;

        always @(posedge clk) begin
            ram[0] <= ifs.rdn ? 12'($urandom) : ramf(int'(ifs.row_addr), int'(ifs.col_addr));
            for (int k = 1; k < 4; k++) ram[k] <= ram[k-1];
            e_s <= clr_rest ? 0 : e_s + 1;
        end
        assign ifs.d_in = ram[gi];

        always @(negedge clk) begin
            if (run)
                mcheck($sformatf("s%0d", gi + 1), mk(4,1,2,1,3,1,1,1,0,0,gi + 1,1), e_s, 12'h0, ifs.rdn,
                       int'(ifs.row_addr), int'(ifs.col_addr), {ifs.b, ifs.g, ifs.r}, ifs.hs, ifs.vs,
                       ifs.de, ifs.line_start, ifs.frame_start);
        end

        initial begin
            int nfs, nde, nbad, nmeas, t_fall;
            logic pde, prdn;
            nfs = 0; nde = 0; nbad = 0; nmeas = 0; t_fall = -1;
            wait (run);
            repeat (12) @(negedge clk);
            pde = ifs.de;
            for (int t = 0; t < 480; t++) begin
                @(negedge clk);
                if (ifs.frame_start) begin
                    nfs++;
                    if (!(ifs.line_start && ifs.de && !pde)) nbad++;
                end
                if (ifs.de) nde++;
                pde = ifs.de;
            end
            check($sformatf("s%0d_fs_per_480", gi + 1), nfs, 10);
            check($sformatf("s%0d_de_per_480", gi + 1), nde, 120);
            check($sformatf("s%0d_fs_align", gi + 1), nbad, 0);
            prdn = ifs.rdn; pde = ifs.de;
            for (int t = 0; t < 150 && nmeas < 3; t++) begin
                @(negedge clk);
                if (prdn && !ifs.rdn) t_fall = t;
                if (!pde && ifs.de && t_fall >= 0) begin
                    check($sformatf("s%0d_de_after_rdn", gi + 1), t - t_fall, gi + 2);
                    nmeas++;
                    t_fall = -1;
                end
                prdn = ifs.rdn; pde = ifs.de;
            end
            check($sformatf("s%0d_rise_count", gi + 1), nmeas, 3);
        end
    end

    function automatic logic probe(input int w);
        case (w)
            0:       return if_a.hs;
            1:       return if_c.hs;
            2:       return g_s[0].ifs.vs;
            default: return 1'b0;
        endcase
    endfunction

    // Width/period of the asserted level, measured between two consecutive assertion edges.
    task automatic measure(input int w, input logic lvl, input int lim, output int width, output int period);
        int start;
        logic prev, cur;
        start = -1; width = 0; period = -1;
        @(negedge clk);
        prev = probe(w);
        for (int t = 1; t <= lim; t++) begin
            @(negedge clk);
            cur = probe(w);
            if (prev !== lvl && cur === lvl) begin
                if (start < 0) start = t;
                else begin
                    period = t - start;
                    break;
                end
            end
            if (start >= 0 && cur === lvl) width++;
            prev = cur;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w, p, n;
        pix_vec_t tbl [6];
        tbl[0] = '{5,   7, 12'h705};
        tbl[1] = '{0,   0, 12'h000};
        tbl[2] = '{255, 1, 12'h1ff};
        tbl[3] = '{256, 3, 12'h300};
        tbl[4] = '{639, 6, 12'h67f};
        tbl[5] = '{100, 2, 12'h264};
        n_err = 0; n_checks = 0; leak_a = 0; leak_b = 0;
        clr_a = 1'b1; clr_rest = 1'b1; run = 1'b0;
        repeat (3) @(negedge clk);
        run = 1'b1;
        check("c_idle_hs", if_c.hs, 1'b0);
        check("c_idle_vs", if_c.vs, 1'b0);
        check("a_rst_hs", if_a.hs, 1'b1);
        check("a_rst_rdn", if_a.rdn, 1'b1);
        clr_a = 1'b0; clr_rest = 1'b0;

        measure(0, 1'b0, 2000, w, p);
        check("a_hs_low", w, 96);
        check("a_hs_period", p, 800);
        measure(1, 1'b1, 2000, w, p);
        check("c_hs_high", w, 96);
        check("c_hs_period", p, 800);
        measure(2, 1'b0, 200, w, p);
        check("s1_vs_low", w, 8);
        check("s1_vs_period", p, 48);

        // Mid-frame reset with the counters at h=400, v=5.
        n = 0;
        while (e_a != 4400 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("a_clr_align", e_a, 4400);
        clr_a = 1'b1;
        @(negedge clk);
        check("a_clr_rdn", if_a.rdn, 1'b1);
        check("a_clr_rgb", {if_a.b, if_a.g, if_a.r}, 12'h0);
        check("a_clr_de", if_a.de, 1'b0);
        clr_a = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (if_a.rdn && n < 30000);
        check("a_first_rdn", n, 144 + 35 * 800 + 1);

        repeat (2500) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            n = tbl[i].y * 1024 + tbl[i].x;
            if (!pix_b.exists(n)) begin
                n_checks++;
                n_err++;
                $display("FAIL b_pix(%0d,%0d): got no pixel expected %0h", tbl[i].x, tbl[i].y, tbl[i].exp_pix);
            end else begin
                check($sformatf("b_pix(%0d,%0d)", tbl[i].x, tbl[i].y), pix_b[n], tbl[i].exp_pix);
            end
        end
        check("a_rgb_leak", leak_a, 0);
        check("b_rgb_leak", leak_b, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
